// File: rtl/oam_dma.sv
// Sprite DMA for $4014: halts the CPU and copies DMA_BYTES bytes from page:00 into OAM.
// Define OAM_DMA_ALIGN_EN to insert the get/put parity alignment cycle after the halt.
module oam_dma #(
  parameter int unsigned DMA_BYTES = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_ce,
  input  logic        cpu_rw,
  input  logic        reg_wr,
  input  logic [7:0]  reg_din,
  input  logic [7:0]  bus_din,
  output logic        rdy,
  output logic        dma_active,
  output logic [15:0] bus_addr,
  output logic        bus_rd,
  output logic [7:0]  oam_din,
  output logic        oam_wr
);

  localparam logic [2:0] StIdle  = 3'd0;
  localparam logic [2:0] StHalt  = 3'd1;
`ifdef OAM_DMA_ALIGN_EN
  localparam logic [2:0] StAlign = 3'd2;
`endif
  localparam logic [2:0] StGet   = 3'd3;
  localparam logic [2:0] StPut   = 3'd4;

  localparam logic [7:0] LastIdx = 8'(DMA_BYTES - 1);

  logic [2:0] state_q, state_d;
  logic [7:0] page_q, page_d;
  logic [7:0] index_q, index_d;
  logic [7:0] oam_din_q, oam_din_d;

`ifdef OAM_DMA_ALIGN_EN
  // High while the current CPU cycle is a get cycle; the first cycle after reset is one.
  logic get_cyc_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      get_cyc_q <= 1'b1;
    end else if (cpu_ce) begin
      get_cyc_q <= ~get_cyc_q;
    end
  end
`endif

  always_comb begin
    state_d   = state_q;
    page_d    = page_q;
    index_d   = index_q;
    oam_din_d = oam_din_q;
    if (cpu_ce) begin
      case (state_q)
        StIdle: begin
          if (reg_wr) begin
            page_d  = reg_din;
            index_d = 8'd0;
            state_d = StHalt;
          end
        end
        StHalt: begin
          // The CPU only stops on a read cycle; writes before it extend the halt.
          if (cpu_rw) begin
`ifdef OAM_DMA_ALIGN_EN
            state_d = get_cyc_q ? StAlign : StGet;
`else
            state_d = StGet;
`endif
          end
        end
`ifdef OAM_DMA_ALIGN_EN
        StAlign: state_d = StGet;
`endif
        StGet: begin
          oam_din_d = bus_din;
          state_d   = StPut;
        end
        StPut: begin
          index_d = index_q + 8'd1;
          state_d = (index_q == LastIdx) ? StIdle : StGet;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      page_q    <= 8'd0;
      index_q   <= 8'd0;
      oam_din_q <= 8'd0;
    end else begin
      state_q   <= state_d;
      page_q    <= page_d;
      index_q   <= index_d;
      oam_din_q <= oam_din_d;
    end
  end

  // Outputs decode straight from state so an asynchronous reset releases the CPU at once.
  always_comb begin
    dma_active = (state_q != StIdle);
    rdy        = ~dma_active;
    bus_rd     = (state_q == StGet);
    bus_addr   = {page_q, index_q};
    oam_din    = oam_din_q;
    oam_wr     = (state_q == StPut) && cpu_ce;
  end

endmodule

// File: tb/tb_oam_dma.sv
// Randomized bench for oam_dma: transaction-level model of halt length, read order and OAM data.
module tb_oam_dma;

  localparam int unsigned N = 256;
`ifdef OAM_DMA_ALIGN_EN
  localparam bit AlignEn = 1'b1;
`else
  localparam bit AlignEn = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cpu_ce = 1'b0;
  logic        cpu_rw = 1'b1;
  logic        reg_wr = 1'b0;
  logic [7:0]  reg_din = 8'd0;
  logic [7:0]  bus_din;
  logic        rdy, dma_active, bus_rd, oam_wr;
  logic [15:0] bus_addr;
  logic [7:0]  oam_din;

  logic [7:0]  mem [65536];

  int unsigned n_checks = 0;
  int unsigned n_err = 0;
  int unsigned cyc = 0;  // CPU cycles since reset; even cycles are get cycles

  logic        s_rdy, s_act, s_bus_rd, s_oam_wr;
  logic [15:0] s_addr;
  logic [7:0]  s_oam_din;

  oam_dma #(.DMA_BYTES(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .cpu_ce    (cpu_ce),
    .cpu_rw    (cpu_rw),
    .reg_wr    (reg_wr),
    .reg_din   (reg_din),
    .bus_din   (bus_din),
    .rdy       (rdy),
    .dma_active(dma_active),
    .bus_addr  (bus_addr),
    .bus_rd    (bus_rd),
    .oam_din   (oam_din),
    .oam_wr    (oam_wr)
  );

  always #5 clk = ~clk;

  // Off-cycle data is corrupted so a latch at the wrong time shows up.
  assign bus_din = bus_rd ? mem[bus_addr] : ~mem[bus_addr];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One CPU cycle, preceded by 0-2 clocks without cpu_ce.
  task automatic cpu_cycle(input logic rw, input logic wr, input logic [7:0] din);
    int unsigned gap;
    gap = $urandom_range(0, 2);
    for (int g = 0; g < int'(gap); g++) begin
      @(posedge clk); #1;
      cpu_ce = 1'b0; reg_wr = 1'b0; cpu_rw = rw;
      @(negedge clk);
      check("oam_wr_gap", 32'(oam_wr), 32'd0);
    end
    @(posedge clk); #1;
    cpu_ce = 1'b1; cpu_rw = rw; reg_wr = wr; reg_din = din;
    @(negedge clk);
    s_rdy = rdy; s_act = dma_active; s_bus_rd = bus_rd;
    s_oam_wr = oam_wr; s_addr = bus_addr; s_oam_din = oam_din;
    cyc++;
  endtask

  task automatic pad(input int unsigned n);
    for (int i = 0; i < int'(n); i++) begin
      cpu_cycle(1'b1, 1'b0, 8'd0);
      check("idle_rdy", 32'(s_rdy), 32'd1);
      check("idle_bus_rd", 32'(s_bus_rd), 32'd0);
    end
  endtask

  task automatic pad_to_parity(input int unsigned par);
    pad($urandom_range(1, 4));
    if ((cyc % 2) != par) pad(1);
  endtask

  // inj_mode: 0 none, 1 reg_wr 0x07 during GET of byte 40, 2 reg_wr on the final PUT.
  task automatic xfer(input logic [7:0] page, input int unsigned wcyc,
                      input int unsigned inj_mode, input bit rst_mid);
    int unsigned c0, h, exp_low, low, act, nrd, nwr, last_rd, inj_k, first_get;
    bit          align, done;
    c0 = cyc;
    cpu_cycle(1'b0, 1'b1, page);
    check("rdy_at_wr", 32'(s_rdy), 32'd1);
    h         = c0 + 1 + wcyc;
    align     = AlignEn && (((h + 1) % 2) == 1);
    exp_low   = 1 + wcyc + (align ? 1 : 0) + 2 * N;
    first_get = h + 1 + (align ? 1 : 0);
    inj_k     = (inj_mode == 1) ? (wcyc + 2 + (align ? 1 : 0) + 80) :
                (inj_mode == 2) ? exp_low : 0;
    low = 0; act = 0; nrd = 0; nwr = 0; last_rd = 0; done = 1'b0;
    for (int unsigned k = 1; k <= exp_low + 8; k++) begin
      if (rst_mid && nrd == 101) begin
        // DUT now enters the PUT of byte 100; reset in the middle of it.
        @(posedge clk); #1;
        cpu_ce = 1'b1; cpu_rw = 1'b1; reg_wr = 1'b0;
        #1;
        check("pre_rst_oam_wr", 32'(oam_wr), 32'd1);
        rst = 1'b1;
        #1;
        check("rst_rdy", 32'(rdy), 32'd1);
        check("rst_oam_wr", 32'(oam_wr), 32'd0);
        check("rst_bus_rd", 32'(bus_rd), 32'd0);
        check("rst_active", 32'(dma_active), 32'd0);
        @(posedge clk); #1;
        cpu_ce = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        cyc = 0;
        return;
      end
      cpu_cycle((k <= wcyc || k == inj_k) ? 1'b0 : 1'b1, (k == inj_k) ? 1'b1 : 1'b0, 8'h07);
      if (s_rdy) begin
        done = 1'b1;
        break;
      end
      low++;
      if (s_act) act++;
      if (s_bus_rd) begin
        check("rd_addr", 32'(s_addr), 32'({page, 8'(nrd)}));
        if (nrd == 0) check("first_get_cyc", cyc - 1, first_get);
        last_rd = cyc - 1;
        nrd++;
      end
      if (s_oam_wr) begin
        check("oam_data", 32'(s_oam_din), 32'(mem[{page, 8'(nwr)}]));
        check("wr_after_rd", cyc - 1, last_rd + 1);
        nwr++;
      end
    end
    check("xfer_done", 32'(done), 32'd1);
    check("rdy_low_cycles", low, exp_low);
    check("active_cycles", act, exp_low);
    check("n_reads", nrd, N);
    check("n_writes", nwr, N);
    if (inj_mode == 2) begin
      cpu_cycle(1'b1, 1'b0, 8'd0);
      check("no_restart_rdy", 32'(s_rdy), 32'd1);
      check("no_restart_act", 32'(s_act), 32'd0);
    end
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) begin
      logic [15:0] a;
      a = 16'(i);
      mem[i] = (a[15:8] == 8'h02) ? (a[7:0] ^ 8'h5A) : 8'($urandom);
    end
    #1 rst = 1'b1;
    #1;
    check("reset_rdy", 32'(rdy), 32'd1);
    check("reset_active", 32'(dma_active), 32'd0);
    check("reset_bus_addr", 32'(bus_addr), 32'd0);
    check("reset_bus_rd", 32'(bus_rd), 32'd0);
    check("reset_oam_din", 32'(oam_din), 32'd0);
    check("reset_oam_wr", 32'(oam_wr), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    cyc = 0;

    pad_to_parity(0);
    xfer(8'h02, 0, 0, 1'b0);
    pad_to_parity(1);
    xfer(8'h02, 0, 0, 1'b0);
    pad($urandom_range(1, 3));
    xfer(8'h02, 3, 0, 1'b0);
    pad($urandom_range(1, 3));
    xfer(8'h02, 0, 1, 1'b0);
    pad($urandom_range(1, 3));
    xfer(8'($urandom), 1, 2, 1'b0);
    pad($urandom_range(1, 3));
    xfer(8'h02, 0, 0, 1'b1);
    pad($urandom_range(1, 3));
    xfer(8'h03, 0, 0, 1'b0);
    for (int t = 0; t < 2; t++) begin
      pad($urandom_range(1, 5));
      xfer(8'($urandom), $urandom_range(0, 2), 0, 1'b0);
    end
    pad(2);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
